// File: rtl/usb_bulk_in_fifo.sv
// Packet FIFO feeding the usb_tlp bulk-IN source: whole packets only, split at MAX_PACKET_SIZE, optional ACK/rewind.
// First byte 2 cycles after m_has_data_o; zero-bubble streaming; source stalls on full or pkt_count saturation.
module usb_bulk_in_fifo #(
  parameter int ADDR_WIDTH      = 11,
  parameter int MAX_PACKET_SIZE = 512,
  parameter int PKT_CNT_WIDTH   = 8,
  parameter int USE_ACK         = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     s_tvalid_i,
  output logic                     s_tready_o,
  input  logic                     s_tlast_i,
  input  logic [7:0]               s_tdata_i,
  output logic                     m_has_data_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic                     m_tlast_o,
  output logic [7:0]               m_tdata_o,
  input  logic                     ack_i,
  input  logic                     rewind_i,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LEN_W = $clog2(MAX_PACKET_SIZE + 1);
  localparam logic [ADDR_WIDTH:0]      FULL_DIST = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]      PTR_ONE   = 1;
  localparam logic [LEN_W-1:0]         LEN_LAST  = LEN_W'(MAX_PACKET_SIZE - 1);
  localparam logic [LEN_W-1:0]         LEN_ONE   = 1;
  localparam logic [PKT_CNT_WIDTH-1:0] CNT_ONE   = 1;
  localparam logic [PKT_CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_WAIT_ACK} rd_state_t;

  logic [8:0]               r_mem [DEPTH];
  logic [8:0]               r_dout;
  logic [ADDR_WIDTH:0]      r_wr_ptr, r_rd_ptr, r_rel_ptr;
  logic [ADDR_WIDTH:0]      w_wr_ptr_nxt, w_rd_ptr_nxt, w_rel_ptr_nxt;
  logic [LEN_W-1:0]         r_wr_len;
  logic [PKT_CNT_WIDTH-1:0] r_pkt_count, w_pkt_count_nxt;
  logic                     r_s_tready, r_has_data;
  rd_state_t                r_state, w_state_nxt;
  logic                     w_wr_fire, w_eop, w_commit, w_release, w_fetch, w_full_nxt;

  assign w_wr_fire    = s_tvalid_i & r_s_tready;
  assign w_eop        = s_tlast_i | (r_wr_len == LEN_LAST);
  assign w_commit     = w_wr_fire & w_eop;
  assign w_wr_ptr_nxt = r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_wr_fire};

  // rd_ptr always sits one past the presented byte, so it is the release point after a last handshake
  always_comb begin
    w_state_nxt   = r_state;
    w_release     = 1'b0;
    w_fetch       = 1'b0;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_rel_ptr_nxt = r_rel_ptr;
    case (r_state)
      S_IDLE: begin
        if (r_pkt_count != '0) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (m_tready_i) begin
          if (!r_dout[8]) begin
            w_fetch = 1'b1;
          end else if (USE_ACK != 0) begin
            w_state_nxt = S_WAIT_ACK;
          end else begin
            w_release   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT_ACK: begin
        if (ack_i) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (rewind_i) begin
          w_rd_ptr_nxt = r_rel_ptr;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_fetch)   w_rd_ptr_nxt  = r_rd_ptr + PTR_ONE;
    if (w_release) w_rel_ptr_nxt = r_rd_ptr;
  end

  always_comb begin
    w_pkt_count_nxt = r_pkt_count;
    case ({w_commit, w_release})
      2'b10:   w_pkt_count_nxt = r_pkt_count + CNT_ONE;
      2'b01:   w_pkt_count_nxt = r_pkt_count - CNT_ONE;
      default: w_pkt_count_nxt = r_pkt_count;
    endcase
  end

  assign w_full_nxt = ((w_wr_ptr_nxt - w_rel_ptr_nxt) == FULL_DIST);

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {w_eop, s_tdata_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rel_ptr   <= '0;
      r_wr_len    <= '0;
      r_pkt_count <= '0;
      r_s_tready  <= 1'b1;
      r_has_data  <= 1'b0;
      r_state     <= S_IDLE;
      r_dout      <= '0;
    end else if (flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rel_ptr   <= '0;
      r_wr_len    <= '0;
      r_pkt_count <= '0;
      r_s_tready  <= 1'b1;
      r_has_data  <= 1'b0;
      r_state     <= S_IDLE;
      r_dout      <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_rel_ptr   <= w_rel_ptr_nxt;
      r_pkt_count <= w_pkt_count_nxt;
      r_s_tready  <= !w_full_nxt && (w_pkt_count_nxt != CNT_MAX);
      r_has_data  <= (w_pkt_count_nxt != '0);
      r_state     <= w_state_nxt;
      if (w_wr_fire) r_wr_len <= w_eop ? '0 : r_wr_len + LEN_ONE;
      if (w_fetch)   r_dout   <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  assign s_tready_o   = r_s_tready;
  assign m_has_data_o = r_has_data;
  assign m_tvalid_o   = (r_state == S_SEND);
  assign m_tlast_o    = (r_state == S_SEND) & r_dout[8];
  assign m_tdata_o    = r_dout[7:0];
  assign pkt_count_o  = r_pkt_count;

endmodule

// File: tb/tb_usb_bulk_in_fifo.sv
// Directed bench: instance A (defaults, no ACK) and instance B (small, USE_ACK=1, 2-bit count).
// Shared stimulus; sel steers s_tvalid and selects which instance's outputs are observed.
module tb_usb_bulk_in_fifo;

  logic       clk = 1'b0;
  logic       rst_n, flush, s_tvalid, s_tlast, m_tready, ack, rewind, sel;
  logic [7:0] s_tdata;

  logic       tready_a, has_a, tvalid_a, tlast_a;
  logic [7:0] tdata_a, cnt_a;
  logic       tready_b, has_b, tvalid_b, tlast_b;
  logic [7:0] tdata_b;
  logic [1:0] cnt_b;

  logic       o_tready, o_has, o_tvalid, o_tlast;
  logic [7:0] o_tdata, o_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_put_to = 0;
  int derr, lerr, bub, got;

  always #5 clk = ~clk;

  usb_bulk_in_fifo u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .s_tvalid_i(s_tvalid & !sel), .s_tready_o(tready_a), .s_tlast_i(s_tlast), .s_tdata_i(s_tdata),
    .m_has_data_o(has_a), .m_tvalid_o(tvalid_a), .m_tready_i(m_tready & !sel),
    .m_tlast_o(tlast_a), .m_tdata_o(tdata_a), .ack_i(ack), .rewind_i(rewind), .pkt_count_o(cnt_a)
  );

  usb_bulk_in_fifo #(.ADDR_WIDTH(6), .MAX_PACKET_SIZE(16), .PKT_CNT_WIDTH(2), .USE_ACK(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .s_tvalid_i(s_tvalid & sel), .s_tready_o(tready_b), .s_tlast_i(s_tlast), .s_tdata_i(s_tdata),
    .m_has_data_o(has_b), .m_tvalid_o(tvalid_b), .m_tready_i(m_tready & sel),
    .m_tlast_o(tlast_b), .m_tdata_o(tdata_b), .ack_i(ack), .rewind_i(rewind), .pkt_count_o(cnt_b)
  );

  assign o_tready = sel ? tready_b : tready_a;
  assign o_has    = sel ? has_b    : has_a;
  assign o_tvalid = sel ? tvalid_b : tvalid_a;
  assign o_tlast  = sel ? tlast_b  : tlast_a;
  assign o_tdata  = sel ? tdata_b  : tdata_a;
  assign o_cnt    = sel ? {6'b0, cnt_b} : cnt_a;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic last);
    bit done;
    done = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      if (o_tready) done = 1'b1;
      step();
    end
    if (!done) n_put_to++;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Pull nbytes with m_tready held high; expected data is first+k, tlast every mps bytes and on the final byte.
  task automatic drain(input int nbytes, input int first, input int mps,
                       output int d_err, output int l_err, output int bubbles, output int n_got);
    int  k;
    bit  exp_nxt;
    k = 0; exp_nxt = 1'b0; d_err = 0; l_err = 0; bubbles = 0;
    m_tready = 1'b1;
    for (int c = 0; c < nbytes * 2 + 50 && k < nbytes; c++) begin
      if (o_tvalid) begin
        if (o_tdata != 8'(first + k)) d_err++;
        if (o_tlast != ((k % mps == mps - 1) || (k == nbytes - 1))) l_err++;
        exp_nxt = !o_tlast;
        k++;
      end else if (exp_nxt) begin
        bubbles++;
      end
      step();
    end
    m_tready = 1'b0;
    n_got = k;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
    m_tready = 1'b0; ack = 1'b0; rewind = 1'b0; sel = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_tready", o_tready, 1);
    chk("rst_has", o_has, 0);
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_cnt", o_cnt, 0);

    // Reset mid-stream: a committed packet on display plus a partial write in flight
    put(8'hA0, 1'b0);
    put(8'hA1, 1'b1);
    step(); step(); step();
    chk("t1_pre_tvalid", o_tvalid, 1);
    put(8'hB0, 1'b0);
    s_tvalid = 1'b1; s_tdata = 8'hB1;
    rst_n = 1'b0;
    step();
    chk("t1_tready", o_tready, 1);
    chk("t1_has", o_has, 0);
    chk("t1_tvalid", o_tvalid, 0);
    chk("t1_tlast", o_tlast, 0);
    chk("t1_tdata", o_tdata, 0);
    chk("t1_cnt", o_cnt, 0);
    s_tvalid = 1'b0;
    rst_n = 1'b1;
    step(); step(); step(); step();
    chk("t1_post_has", o_has, 0);
    chk("t1_post_tvalid", o_tvalid, 0);

    // Three-byte packet, latency and readback
    m_tready = 1'b1;
    put(8'hA1, 1'b0);
    put(8'hA2, 1'b0);
    chk("t2_partial_has", o_has, 0);
    put(8'hA3, 1'b1);
    chk("t2_has", o_has, 1);
    chk("t2_tvalid0", o_tvalid, 0);
    step();
    chk("t2_tvalid1", o_tvalid, 0);
    step();
    chk("t2_tvalid2", o_tvalid, 1);
    chk("t2_d1", o_tdata, 8'hA1);
    chk("t2_l1", o_tlast, 0);
    step();
    chk("t2_d2", o_tdata, 8'hA2);
    chk("t2_l2", o_tlast, 0);
    step();
    chk("t2_d3", o_tdata, 8'hA3);
    chk("t2_l3", o_tlast, 1);
    step();
    chk("t2_end_tvalid", o_tvalid, 0);
    chk("t2_end_cnt", o_cnt, 0);
    chk("t2_end_has", o_has, 0);
    m_tready = 1'b0;

    // 1100-byte stream split at 512
    for (int i = 0; i < 1100; i++) begin
      if (i == 1099) chk("t3_cnt_before", o_cnt, 2);
      put(8'(i), i == 1099);
    end
    chk("t3_cnt_after", o_cnt, 3);
    drain(1100, 0, 512, derr, lerr, bub, got);
    chk("t3_got", got, 1100);
    chk("t3_data_err", derr, 0);
    chk("t3_last_err", lerr, 0);
    chk("t3_bubbles", bub, 0);
    chk("t3_cnt_end", o_cnt, 0);

    // Fill to capacity with no reads, then free one packet
    for (int i = 0; i < 2048; i++) begin
      if (i == 2047) chk("t4_tready_pre", o_tready, 1);
      put(8'(i), 1'b0);
    end
    chk("t4_full_tready", o_tready, 0);
    chk("t4_full_cnt", o_cnt, 4);
    step(); step(); step();
    chk("t4_stall_tready", o_tready, 0);
    drain(512, 0, 512, derr, lerr, bub, got);
    chk("t4_p1_got", got, 512);
    chk("t4_p1_data_err", derr, 0);
    chk("t4_p1_last_err", lerr, 0);
    chk("t4_tready_back", o_tready, 1);
    chk("t4_cnt_after_rel", o_cnt, 3);
    for (int i = 2048; i < 2100; i++) put(8'(i), i == 2099);
    chk("t4_cnt_all", o_cnt, 4);
    drain(1588, 512, 512, derr, lerr, bub, got);
    chk("t4_rest_got", got, 1588);
    chk("t4_rest_data_err", derr, 0);
    chk("t4_rest_last_err", lerr, 0);
    chk("t4_rest_bubbles", bub, 0);
    chk("t4_cnt_end", o_cnt, 0);

    // Commit and release on the same edge, then flush
    put(8'h61, 1'b0);
    put(8'h62, 1'b1);
    step(); step();
    chk("t6_tvalid", o_tvalid, 1);
    chk("t6_d1", o_tdata, 8'h61);
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 8'h71; s_tlast = 1'b0;
    step();
    chk("t6_mid_cnt", o_cnt, 1);
    chk("t6_d2", o_tdata, 8'h62);
    chk("t6_l2", o_tlast, 1);
    s_tdata = 8'h72; s_tlast = 1'b1;
    step();
    chk("t6_same_cnt", o_cnt, 1);
    chk("t6_same_has", o_has, 1);
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_fl_cnt", o_cnt, 0);
    chk("t6_fl_has", o_has, 0);
    chk("t6_fl_tvalid", o_tvalid, 0);
    chk("t6_fl_tready", o_tready, 1);
    step(); step(); step(); step();
    chk("t6_fl_late_tvalid", o_tvalid, 0);

    // ACK / rewind on instance B
    sel = 1'b1;
    step();
    put(8'd10, 1'b0);
    put(8'd11, 1'b0);
    put(8'd12, 1'b1);
    put(8'd20, 1'b0);
    put(8'd21, 1'b1);
    chk("t5_cnt2", o_cnt, 2);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t5_ack_ignored", o_cnt, 2);
    chk("t5_hold_d", o_tdata, 10);
    drain(3, 10, 16, derr, lerr, bub, got);
    chk("t5_first_got", got, 3);
    chk("t5_first_err", derr + lerr, 0);
    step();
    chk("t5_wait_tvalid", o_tvalid, 0);
    chk("t5_wait_cnt", o_cnt, 2);
    rewind = 1'b1;
    step();
    rewind = 1'b0;
    drain(3, 10, 16, derr, lerr, bub, got);
    chk("t5_resend_got", got, 3);
    chk("t5_resend_err", derr + lerr, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t5_ack_cnt", o_cnt, 1);
    drain(2, 20, 16, derr, lerr, bub, got);
    chk("t5_next_got", got, 2);
    chk("t5_next_err", derr + lerr, 0);
    ack = 1'b1; rewind = 1'b1;
    step();
    ack = 1'b0; rewind = 1'b0;
    chk("t5_both_cnt", o_cnt, 0);
    step(); step(); step(); step();
    chk("t5_both_tvalid", o_tvalid, 0);

    // Packet counter saturation on B (max 3)
    put(8'd1, 1'b1);
    put(8'd2, 1'b1);
    chk("sat_tready_pre", o_tready, 1);
    put(8'd3, 1'b1);
    chk("sat_cnt", o_cnt, 3);
    chk("sat_tready", o_tready, 0);
    step(); step();
    chk("sat_tready_hold", o_tready, 0);
    drain(1, 1, 16, derr, lerr, bub, got);
    chk("sat_rd_err", derr + lerr, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("sat_rel_cnt", o_cnt, 2);
    chk("sat_rel_tready", o_tready, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sat_fl_cnt", o_cnt, 0);

    chk("put_timeouts", n_put_to, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
